// File: rtl/mano_memory.sv
// Unified word memory for the Mano CPU with a byte-stream program loader
// that holds the CPU in reset while it fills memory from LOAD_BASE upward.
module mano_memory #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 16,
    parameter int          MEM_DEPTH  = 4096,
    parameter logic [11:0] LOAD_BASE  = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  we_n,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_reset_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic [11:0]           load_count,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LOAD_HI = 2'd1;
    localparam logic [1:0] ST_LOAD_LO = 2'd2;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [1:0]  state_q, state_d;
    logic        crn_q, crn_d;
    logic [11:0] count_q, count_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] ptr_q, ptr_d;

    logic                  mem_we;
    logic [11:0]           mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Only the low 12 address bits select a word; the rest are don't-care.
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_WIDTH-1:12];

    assign cpu_rdata   = mem[addr[11:0]];
    assign cpu_reset_n = crn_q;
    assign load_count  = count_q;
    assign dbg_state   = state_q;

    // Loader handshake: a byte transfers on a clock edge where load_valid and
    // load_ready are both high; load_ready is high only in the LOAD states.
    assign load_ready = (state_q != ST_RUN);
    assign load_busy  = (state_q != ST_RUN);

    always_comb begin
        state_d   = state_q;
        crn_d     = crn_q;
        count_d   = count_q;
        hi_d      = hi_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = addr[11:0];
        mem_wdata = cpu_wdata;

        if (reset) begin
            state_d = ST_RUN;
            crn_d   = 1'b0;
            count_d = 12'd0;
            hi_d    = 8'd0;
            ptr_d   = LOAD_BASE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    crn_d  = 1'b1;
                    mem_we = ~we_n;
                    if (load_start) begin
                        state_d = ST_LOAD_HI;
                        ptr_d   = LOAD_BASE;
                        count_d = 12'd0;
                        crn_d   = 1'b0;
                    end
                end
                ST_LOAD_HI: begin
                    if (load_valid) begin
                        hi_d = load_byte;
                        if (load_last) begin
                            // Odd-length stream: final word is padded low.
                            mem_we    = 1'b1;
                            mem_waddr = ptr_q;
                            mem_wdata = {load_byte, 8'h00};
                            count_d   = count_q + 12'd1;
                            state_d   = ST_RUN;
                            crn_d     = 1'b1;
                        end else begin
                            state_d = ST_LOAD_LO;
                        end
                    end
                end
                ST_LOAD_LO: begin
                    if (load_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q;
                        mem_wdata = {hi_q, load_byte};
                        ptr_d     = ptr_q + 12'd1;
                        count_d   = count_q + 12'd1;
                        if (load_last) begin
                            state_d = ST_RUN;
                            crn_d   = 1'b1;
                        end else begin
                            state_d = ST_LOAD_HI;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        crn_q   <= crn_d;
        count_q <= count_d;
        hi_q    <= hi_d;
        ptr_q   <= ptr_d;
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
